// File: rtl/sd_host.sv
// rtl/sd_host.sv - CPU-facing SD sector host: LBA/control registers, 512x8 buffer, command FSM.
// Optional SD_HOST_RETRY_EN: failed attempts re-issue up to 2 times; count reads in reg 7 [7:6].
module sd_host (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  io_a,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [7:0]  io_din,
  output logic [7:0]  io_dout,
  output logic        sd_command,
  output logic        sd_rw,
  output logic [31:0] sd_lba,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic [3:0]  sd_error,
  input  logic [1:0]  sd_card,
  input  logic [9:0]  sd_a,
  input  logic [7:0]  sd_o,
  input  logic        sd_w,
  output logic [7:0]  sd_i
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_RUN, S_FIN} state_t;

  state_t      state_q;
  logic        busy_q, done_q, sd_command_q, sd_rw_q;
  logic [3:0]  err_q, timer_q;
  logic [1:0]  card_q, retry_q;
  logic [8:0]  ptr_q, ptr_d;
  logic [31:0] lba_q;
  logic [7:0]  io_dout_q, io_dout_d, sd_i_q;
  logic [7:0]  sector_mem [0:511];

  logic cpu_rd, ctrl_wr, start, data_wr, data_rd, lba_wr, retry_ok;
  logic unused_sd_a9;

  assign unused_sd_a9 = sd_a[9];

`ifdef SD_HOST_RETRY_EN
  assign retry_ok = (retry_q != 2'd2);
`else
  assign retry_ok = 1'b0;
`endif

  // Write wins over a simultaneous read.
  assign cpu_rd  = io_re & ~io_we;
  assign ctrl_wr = io_we && (io_a == 3'd4);
  assign start   = ctrl_wr && (state_q == S_IDLE) && (io_din[0] || io_din[1]);
  assign data_wr = io_we && (io_a == 3'd5) && !busy_q;
  assign data_rd = cpu_rd && (io_a == 3'd5) && !busy_q;
  assign lba_wr  = io_we && !io_a[2] && !busy_q;
  assign ptr_d   = ptr_q + 9'd1;

  always_comb begin
    io_dout_d = 8'h00;
    case (io_a)
      3'd0: io_dout_d = lba_q[7:0];
      3'd1: io_dout_d = lba_q[15:8];
      3'd2: io_dout_d = lba_q[23:16];
      3'd3: io_dout_d = lba_q[31:24];
      3'd4: io_dout_d = {busy_q, done_q, card_q, err_q};
      3'd5: io_dout_d = busy_q ? 8'hFF : sector_mem[ptr_q];
      3'd6: io_dout_d = ptr_q[7:0];
      default: io_dout_d = {retry_q, 5'b0, ptr_q[8]};
    endcase
  end

  // Buffer is not reset; the engine port and the CPU data port share it.
  always_ff @(posedge clock) begin
    if (sd_w) sector_mem[sd_a[8:0]] <= sd_o;
    if (data_wr) sector_mem[ptr_q] <= io_din;
    sd_i_q <= sector_mem[sd_a[8:0]];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 4'h0;
      card_q       <= 2'b00;
      retry_q      <= 2'b00;
      timer_q      <= 4'h0;
      ptr_q        <= 9'h000;
      lba_q        <= 32'h0;
      sd_command_q <= 1'b0;
      sd_rw_q      <= 1'b0;
      io_dout_q    <= 8'h00;
    end else begin
      if (cpu_rd) io_dout_q <= io_dout_d;
      if (lba_wr) begin
        case (io_a[1:0])
          2'd0: lba_q[7:0]   <= io_din;
          2'd1: lba_q[15:8]  <= io_din;
          2'd2: lba_q[23:16] <= io_din;
          default: lba_q[31:24] <= io_din;
        endcase
      end
      if (data_wr || data_rd) ptr_q <= ptr_d;
      if (ctrl_wr && io_din[7]) begin
        done_q <= 1'b0;
        err_q  <= 4'h0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_ISSUE;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 4'h0;
            ptr_q        <= 9'h000;
            retry_q      <= 2'b00;
            sd_command_q <= 1'b1;
            sd_rw_q      <= ~io_din[0];
          end
        end
        S_ISSUE: begin
          sd_command_q <= 1'b0;
          timer_q      <= 4'h0;
          state_q      <= S_ARM;
        end
        S_ARM: begin
          if (sd_busy) begin
            state_q <= S_RUN;
          end else if (timer_q == 4'hF) begin
            err_q <= 4'hF;
            if (retry_ok) begin
              retry_q      <= retry_q + 2'd1;
              sd_command_q <= 1'b1;
              state_q      <= S_ISSUE;
            end else begin
              state_q <= S_FIN;
            end
          end else begin
            timer_q <= timer_q + 4'h1;
          end
        end
        S_RUN: begin
          if (!sd_busy) begin
            err_q <= sd_error;
            if ((sd_error != 4'h0) && retry_ok) begin
              retry_q      <= retry_q + 2'd1;
              sd_command_q <= 1'b1;
              state_q      <= S_ISSUE;
            end else begin
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          card_q  <= sd_card;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_dout    = io_dout_q;
  assign sd_command = sd_command_q;
  assign sd_rw      = sd_rw_q;
  assign sd_lba     = lba_q;
  assign sd_i       = sd_i_q;

endmodule

// File: doc/sd_host.md
SD_HOST -- requirements
Module: sd_host

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, 25 MHz.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: io_a  in  3  CPU register index.
REQ-004 SHALL have ports: io_we  in  1  CPU write strobe, 1 clock.
REQ-005 SHALL have ports: io_re  in  1  CPU read strobe, 1 clock.
REQ-006 SHALL have ports: io_din  in  8  CPU write data.
REQ-007 SHALL have ports: io_dout  out  8  CPU read data, registered.
REQ-008 SHALL have ports: sd_command  out  1  start pulse to SD engine.
REQ-009 SHALL have ports: sd_rw  out  1  0=read, 1=write.
REQ-010 SHALL have ports: sd_lba  out  32  sector number.
REQ-011 SHALL have ports: sd_busy  in  1  engine busy.
REQ-012 SHALL have ports: sd_done  in  1  engine done strobe.
REQ-013 SHALL have ports: sd_error  in  4  engine error code.
REQ-014 SHALL have ports: sd_card  in  2  card type.
REQ-015 SHALL have ports: sd_a  in  10  engine buffer address; bits [8:0] used.
REQ-016 SHALL have ports: sd_o  in  8  engine data to buffer.
REQ-017 SHALL have ports: sd_w  in  1  engine buffer write strobe.
REQ-018 SHALL have ports: sd_i  out  8  buffer data to engine.

Function
REQ-019 SHALL contain a 512x8 sector buffer: sd_w=1 writes sd_o to buf[sd_a[8:0]]; sd_i is buf[sd_a[8:0]] registered, 1-clock latency.
REQ-020 SHALL map registers: 0..3 = LBA bytes [7:0]..[31:24] (R/W); 4 = control/status; 5 = data port; 6 = ptr[7:0]; 7 = {7'b0, ptr[8]}.
REQ-021 SHALL return status on read of 4: {busy, done, card[1:0], err[3:0]}.
REQ-022 SHALL, on write of 4 while idle: bit0=1 start read; bit1=1 start write (bit0 wins if both set); bit7=1 clear done and err; start also clears done, err, ptr.
REQ-023 SHALL ignore start bits while busy; bit7 is honoured at any time.
REQ-024 SHALL, on data-port read, return buf[ptr]; on data-port write, store io_din to buf[ptr]; either access increments ptr mod 512 (511 -> 0).
REQ-025 SHALL, while busy, ignore data-port and LBA writes and return 8'hFF on data-port reads, with ptr unchanged.
REQ-026 SHALL present io_dout one clock after io_re; unmapped bits read 0.
REQ-027 SHALL use FSM IDLE -> ISSUE -> ARM -> RUN -> FIN -> IDLE.
REQ-028 SHALL assert sd_command for exactly 1 clock in ISSUE, with sd_rw and sd_lba stable from ISSUE until FIN.
REQ-029 SHALL, in ARM, wait for sd_busy=1; if 16 clocks elapse without it, set err=4'hF and go to FIN.
REQ-030 SHALL, in RUN, latch err<=sd_error when sd_busy falls; sd_done=1 marks success (err=0).
REQ-031 SHALL, in FIN, latch card<=sd_card, set done=1 and busy=0.
REQ-032 SHALL hold busy=1 in ISSUE, ARM and RUN.
REQ-033 SHALL give io_we precedence over io_re when both are asserted in the same clock.

Reset
REQ-034 SHALL, on reset_n=0, immediately clear: state=IDLE, busy, done, err, card, ptr, LBA, sd_command, sd_rw, io_dout (all 0); buffer contents undefined.
REQ-035 SHALL, on reset mid-transfer, abort and not resume; engine-side completion is ignored until the next start.

Configuration
REQ-036 SHALL, with SD_HOST_RETRY_EN defined, re-enter ISSUE when RUN ends with err!=0 or ARM times out, up to 2 retries (3 attempts); it reports the last err; the retry count is readable in status-read bits of register 7 [7:6].
REQ-037 SHALL, without SD_HOST_RETRY_EN, make every error go straight to FIN; register 7 [7:6] read 0.

Verification
REQ-038 SHALL cover: write LBA=0x00001234, ctrl=0x01; model engine busy 3 clocks later, writes 512 bytes k&0xFF, done -> status 0x40|card<<4; data port reads 0x00..0xFF twice.
REQ-039 SHALL cover: 511 data-port writes then ptr=0x1FF; next access wraps ptr to 0x000.
REQ-040 SHALL cover: engine never asserts busy -> after 16 clocks status err=0xF, done=1, busy=0.
REQ-041 SHALL cover: engine ends with sd_error=3 -> status 0x43 without retry; with SD_HOST_RETRY_EN exactly 3 sd_command pulses, then status 0x43, reg7[7:6]=2.
REQ-042 SHALL cover: ctrl=0x01 during RUN -> no extra sd_command; data-port read returns 0xFF.
REQ-043 SHALL cover: reset_n low during RUN -> all outputs 0 in the same clock; later sd_done leaves done=0.
